// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter/sequencer sharing one UART transmitter
// among NUM_REQ byte producers. A byte is taken through a valid/ready handshake,
// held in tx_data, and launched with tx_enable. The block then waits for tx_busy
// to rise and then fall before it grants the next byte.
//
// Optional feature: define TX_ARB_WATCHDOG_EN to abort a launch that never sees
// tx_busy rise within LAUNCH_TIMEOUT cycles. When it is undefined, timeout is tied 0.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   req_valid  per-requester byte-available flags
//   req_data   packed requester bytes, byte i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  one-hot combinational accept, only in IDLE
//   tx_enable  registered transmitter enable
//   tx_data    registered byte to transmitter
//   tx_busy    transmitter busy
//   grant_id   index of requester owning the current frame
//   active     high from accept until frame completion
//   timeout    one-cycle watchdog abort pulse
module tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned LAUNCH_TIMEOUT = 16384,
  localparam int unsigned ID_W          = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_enable,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          active,
  output logic                          timeout
);

  // Reject out-of-range configurations at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || LAUNCH_TIMEOUT == 0) begin : g_bad_cfg
    $error("tx_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] next_ptr;
  logic            grant_found;
  logic            accept;
  logic [31:0]     scan_idx;

`ifdef TX_ARB_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(LAUNCH_TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && req_valid[ID_W'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(scan_idx);
      end
    end
  end

  assign next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // Reset gates the grant so nothing is consumed while reset is held.
  assign accept    = reset && (state == IDLE) && !tx_busy && grant_found;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

`ifndef TX_ARB_WATCHDOG_EN
  assign timeout = 1'b0;
`endif

  // Sequencer: state and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      tx_enable <= 1'b0;
      tx_data   <= '0;
      grant_id  <= '0;
      active    <= 1'b0;
      rr_ptr    <= '0;
`ifdef TX_ARB_WATCHDOG_EN
      timeout   <= 1'b0;
      wd_cnt    <= '0;
`endif
    end else begin
`ifdef TX_ARB_WATCHDOG_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data   <= req_data[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            grant_id  <= grant_idx;
            active    <= 1'b1;
            rr_ptr    <= next_ptr;
            tx_enable <= 1'b1;
            state     <= LAUNCH;
`ifdef TX_ARB_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
          end
        end
        LAUNCH: begin
          if (tx_busy) begin
            tx_enable <= 1'b0;
            state     <= WAIT_DONE;
          end
`ifdef TX_ARB_WATCHDOG_EN
          // Abort on the LAUNCH_TIMEOUT-th edge after entry; the byte is dropped.
          else if (wd_cnt == WD_W'(LAUNCH_TIMEOUT - 1)) begin
            tx_enable <= 1'b0;
            active    <= 1'b0;
            timeout   <= 1'b1;
            state     <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed self-checking bench for tx_arbiter (NUM_REQ=4, DATA_WIDTH=8,
// LAUNCH_TIMEOUT=20). tx_busy is driven directly as a scripted transmitter.
module tb_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_enable;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout;

  int tests = 0;
  int fails = 0;

  tx_arbiter #(
    .NUM_REQ       (4),
    .DATA_WIDTH    (8),
    .LAUNCH_TIMEOUT(20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx_enable(tx_enable),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .active   (active),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 4'hF;
    req_data  = 32'h13121110;
    tx_busy   = 1'b0;

    // Reset held 3 cycles with every requester valid.
    repeat (3) tick();
    chk("rst_tx_enable", 32'(tx_enable), 32'h0);
    chk("rst_tx_data",   32'(tx_data),   32'h0);
    chk("rst_grant_id",  32'(grant_id),  32'h0);
    chk("rst_active",    32'(active),    32'h0);
    chk("rst_timeout",   32'(timeout),   32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);

    // Single request from requester 2.
    reset     = 1'b1;
    req_valid = 4'b0100;
    req_data  = 32'h00A50000;
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("single_ready_drop", 32'(req_ready), 32'h0);
    chk("single_data",   32'(tx_data),   32'hA5);
    chk("single_grant",  32'(grant_id),  32'h2);
    chk("single_active", 32'(active),    32'h1);
    chk("single_en_rise", 32'(tx_enable), 32'h1);
    repeat (5) tick();
    chk("single_en_hold", 32'(tx_enable), 32'h1);
    tx_busy = 1'b1;
    tick();
    chk("single_en_fall", 32'(tx_enable), 32'h0);
    chk("single_active_busy", 32'(active), 32'h1);
    repeat (49) tick();
    chk("single_data_stable", 32'(tx_data), 32'hA5);
    chk("single_active_hold", 32'(active),  32'h1);
    tx_busy = 1'b0;
    tick();
    chk("single_active_fall", 32'(active), 32'h0);

    // Fairness from a cleared pointer: 0,1,2,3,0.
    reset = 1'b0;
    tick();
    reset     = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'h13121110;
    for (int f = 0; f < 5; f++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'h1 << (f % 4));
      tick();
      chk("rr_data",  32'(tx_data),  32'h10 + 32'(f % 4));
      chk("rr_grant", 32'(grant_id), 32'(f % 4));
      tx_busy = 1'b1;
      tick();
      tick();
      chk("rr_ready_wait", 32'(req_ready), 32'h0);
      tx_busy = 1'b0;
      tick();
    end

    // Busy while IDLE blocks grants; pointer now at requester 1.
    tx_busy = 1'b1;
    #1;
    chk("busy_idle_ready0", 32'(req_ready), 32'h0);
    repeat (3) tick();
    chk("busy_idle_ready1", 32'(req_ready), 32'h0);
    chk("busy_idle_active", 32'(active),    32'h0);
    tx_busy = 1'b0;
    #1;
    chk("busy_drop_ready", 32'(req_ready), 32'h2);
    tick();
    chk("busy_drop_grant", 32'(grant_id), 32'h1);
    chk("busy_drop_data",  32'(tx_data),  32'h11);

    // Reset during WAIT_DONE with the transmitter still busy.
    tx_busy = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_active", 32'(active),    32'h0);
    chk("midrst_en",     32'(tx_enable), 32'h0);
    chk("midrst_grant",  32'(grant_id),  32'h0);
    reset = 1'b1;
    #1;
    chk("midrst_ready0", 32'(req_ready), 32'h0);
    tick();
    chk("midrst_ready1", 32'(req_ready), 32'h0);
    chk("midrst_active1", 32'(active),   32'h0);
    tx_busy = 1'b0;
    #1;
    chk("midrst_regrant_ready", 32'(req_ready), 32'h1);
    tick();
    chk("midrst_regrant_data", 32'(tx_data), 32'h10);

    // Launch with busy never rising.
`ifdef TX_ARB_WATCHDOG_EN
    repeat (19) tick();
    chk("wd_en_before",  32'(tx_enable), 32'h1);
    chk("wd_to_before",  32'(timeout),   32'h0);
    tick();
    chk("wd_en_drop",    32'(tx_enable), 32'h0);
    chk("wd_timeout",    32'(timeout),   32'h1);
    chk("wd_active",     32'(active),    32'h0);
    chk("wd_next_ready", 32'(req_ready), 32'h2);
    tick();
    chk("wd_to_pulse",   32'(timeout),   32'h0);
    chk("wd_next_grant", 32'(grant_id),  32'h1);
`else
    repeat (30) tick();
    chk("nowd_en_hold",  32'(tx_enable), 32'h1);
    chk("nowd_active",   32'(active),    32'h1);
    chk("nowd_timeout",  32'(timeout),   32'h0);
    chk("nowd_ready",    32'(req_ready), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter (`TxUART` path inside `Tx_top`) among `NUM_REQ` byte producers. It accepts one byte at a time through a valid/ready handshake and holds it in a local register. It then drives the transmitter's `enable`/`i_data` and tracks `o_busy` until the frame is finished. It sits between the system-side producers and `Tx_top`, in the 48 MHz `clk` domain.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 8, byte width, matches transmitter `INPUT_DATA_WIDTH`
- `LAUNCH_TIMEOUT`, 16384, max cycles to wait for `tx_busy` to rise after `tx_enable` (watchdog only)
- `clk`  input  1  system clock, 48 MHz
- `reset`  input  1  synchronous, active-low reset
- `req_valid`  input  NUM_REQ  requester i has a byte
- `req_data`  input  NUM_REQ*DATA_WIDTH  byte i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  output  NUM_REQ  one-hot accept pulse; byte is consumed on the edge where valid&ready
- `tx_enable`  output  1  to transmitter `enable`
- `tx_data`  output  DATA_WIDTH  to transmitter `i_data`
- `tx_busy`  input  1  from transmitter `o_busy`
- `grant_id`  output  $clog2(NUM_REQ)  index of the requester owning the current frame
- `active`  output  1  high from accept until the frame completes
- `timeout`  output  1  one-cycle pulse on watchdog abort (constant 0 when watchdog is compiled out)

## Operation
- FSM states: IDLE, LAUNCH, WAIT_DONE.
- **IDLE**
  - If `tx_busy`=0 and any `req_valid` is high, pick the first valid index scanning from `rr_ptr` upward, modulo NUM_REQ.
  - `req_ready[g]` is asserted combinationally in this cycle.
  - On the edge: `tx_data` ← `req_data[g]`, `grant_id` ← g, `active` ← 1, `rr_ptr` ← (g+1) mod NUM_REQ, go to LAUNCH.
  - If `tx_busy`=1 in IDLE (stray or still-draining frame), nothing is granted and `req_ready` stays 0.
- **LAUNCH**
  - `tx_enable`=1 (registered).
  - Stay until `tx_busy`=1, then go to WAIT_DONE with `tx_enable` ← 0.
- **WAIT_DONE**
  - Stay while `tx_busy`=1.
  - On `tx_busy`=0: `active` ← 0, go to IDLE.
- `tx_data` holds stable from accept until the next accept; it is never changed while `active`=1.
- `req_ready` is 0 outside IDLE and at most one bit is ever high.
- Requesters may drop `req_valid` at any time without ready; no byte is taken unless valid&ready coincide.

## Timing
- Reset values (registered, synchronous, `reset`=0 at the edge): state IDLE, `tx_enable` 0, `tx_data` 0, `grant_id` 0, `active` 0, `timeout` 0, `rr_ptr` 0.
- `reset`=0 overrides everything, including mid-frame. The transmitter is not aborted by this block, but re-grant waits for `tx_busy`=0.
- Accept to `tx_enable` high: 1 cycle.
- `tx_enable` falls on the cycle after `tx_busy` is first seen high.
- `tx_busy` falling to next accept is 2 cycles minimum: WAIT_DONE→IDLE, then grant in IDLE.
- Simultaneous requests: strict round-robin. With all valid continuously and NUM_REQ=4, the order is 0,1,2,3,0,…
- `tx_busy` already 1 on entry to LAUNCH: the transition to WAIT_DONE happens on the next edge.

## Configuration
- `TX_ARB_WATCHDOG_EN` defined:
  - A 15-bit-sufficient counter runs in LAUNCH.
  - If `tx_busy` is not seen within `LAUNCH_TIMEOUT` cycles: `tx_enable` ← 0, `active` ← 0, `timeout` pulses 1 cycle, go to IDLE.
  - The byte is dropped and not retried; `rr_ptr` is already advanced.
- Not defined:
  - No counter; LAUNCH waits indefinitely.
  - `timeout` is tied 0.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with all `req_valid`=1 → all outputs at their reset values, `req_ready`=0.
- Single request: `req_valid`=4'b0100, data 8'hA5; model raises busy 5 cycles after enable and holds it 50 cycles → `req_ready[2]` pulses once, `tx_data`=8'hA5, `grant_id`=2, `tx_enable` high 6 cycles, `active` falls 1 cycle after busy falls.
- Fairness: all four valid continuously with data 8'h10..8'h13 → frames go out in order 10,11,12,13,10; no requester is granted twice before the others.
- Busy in IDLE: `tx_busy` forced 1 with `req_valid`=1 → no `req_ready` until busy drops, then grant within 1 cycle.
- Reset mid-frame: assert `reset`=0 during WAIT_DONE → state IDLE and `active`=0 next edge; no grant while busy remains 1.
- Watchdog (macro defined, `LAUNCH_TIMEOUT`=20): busy never rises → `tx_enable` drops, and `timeout` pulses exactly once, both 20 cycles after LAUNCH entry; next requester is granted afterward.
